// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: D = A - B - b_in, one bit per clock, LSB first.
// A single full-subtractor cell is reused WIDTH times. The caller uses a
// start/busy/done handshake. D and b_out change only on the DONE cycle.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             b_out
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh, b_sh, res;
   logic             br;
   logic [CW-1:0]    cnt;
   logic             d_bit, br_nxt;

   // Full-subtractor cell acting on the current LSBs and the running borrow.
   always_comb begin
      d_bit  = a_sh[0] ^ b_sh[0] ^ br;
      br_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
   end

   // Control FSM and datapath. All outputs are registered. A start is taken
   // only in IDLE, so a start during SHIFT or DONE is dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         res   <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         D     <= '0;
         b_out <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= A;
                  b_sh  <= B;
                  br    <= b_in;
                  res   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               br   <= br_nxt;
               res  <= {d_bit, res[WIDTH-1:1]};
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  busy  <= 1'b0;
                  state <= DONE;
               end
            end
            DONE: begin
               // br already holds the borrow out of the MSB cell
               D     <= res;
               b_out <= br;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor. A cycle-timed model predicts
// busy/done/D/b_out every cycle from the operation timeline. Directed
// operations also check literal results and latency.
module tb_serial_subtractor;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] A = '0;
   logic [WIDTH-1:0] B = '0;
   logic             b_in = 1'b0;
   logic             busy, done, b_out;
   logic [WIDTH-1:0] D;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .A(A), .B(B), .b_in(b_in),
      .busy(busy), .done(done), .D(D), .b_out(b_out)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Timeline model. Suppose an op is accepted at edge e0. Busy is high after
   // edges e0 .. e0+WIDTH-1. Done is high after edge e0+WIDTH+1, and the
   // result appears at the same point. The next start is accepted from edge
   // e0+WIDTH+2 on.
   int               edge_n = 0;
   int               e0 = 0;
   bit               op_live = 1'b0;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] p_D, m_D;
   logic             p_bo, m_bo, m_busy, m_done;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_live = 1'b0;
         m_D = '0; m_bo = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      end else begin
         edge_n++;
         if (start && !(op_live && edge_n < e0 + WIDTH + 2)) begin
            op_live = 1'b1;
            e0 = edge_n;
            diff = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, b_in};
            p_D = diff[WIDTH-1:0];
            p_bo = diff[WIDTH];
         end
         m_busy = op_live && edge_n >= e0 && edge_n < e0 + WIDTH;
         m_done = op_live && edge_n == e0 + WIDTH + 1;
         if (m_done) begin
            m_D = p_D;
            m_bo = p_bo;
         end
      end
   end

   // Check the DUT against the model on every falling edge.
   always @(negedge clk) begin
      chk("cyc_busy", busy, m_busy);
      chk("cyc_done", done, m_done);
      chk("cyc_D", D, m_D);
      chk("cyc_b_out", b_out, m_bo);
   end

   // Run one op from IDLE. Check latency, busy length and the literal result.
   task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bi, input logic [WIDTH-1:0] ed, input logic eb);
      int k, nb;
      @(posedge clk); #1;
      A = a; B = b; b_in = bi; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      k = 0;
      nb = busy ? 1 : 0;
      while (!done && k < 20) begin
         @(posedge clk); #1;
         k++;
         if (busy) nb++;
      end
      chk("op_latency", k, WIDTH + 1);
      chk("op_busy_cycles", nb, WIDTH);
      chk("op_D", D, ed);
      chk("op_b_out", b_out, eb);
   endtask

   initial begin
      int nd, nbusy;
      logic [WIDTH:0] r;

      // Check the reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_D", D, 0);
      chk("rst_b_out", b_out, 0);
      #2 reset_n = 1'b1;

      // Directed, hand-computed cases.
      do_op(4'd9, 4'd3, 1'b0, 4'h6, 1'b0);
      do_op(4'd3, 4'd9, 1'b0, 4'hA, 1'b1);
      do_op(4'd5, 4'd5, 1'b1, 4'hF, 1'b1);
      do_op(4'd0, 4'd0, 1'b0, 4'h0, 1'b0);
      do_op(4'd15, 4'd0, 1'b1, 4'hE, 1'b0);
      do_op(4'd0, 4'd15, 1'b1, 4'h0, 1'b1);

      // Start and operand changes while busy are ignored.
      @(posedge clk); #1;
      A = 4'd9; B = 4'd3; b_in = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      A = 4'd1; B = 4'd14; start = 1'b1;
      repeat (2) @(posedge clk);
      #1 start = 1'b0;
      nd = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) nd++;
      end
      chk("busy_ign_dones", nd, 1);
      chk("busy_ign_D", D, 4'h6);
      chk("busy_ign_b_out", b_out, 1'b0);
      do_op(4'd1, 4'd14, 1'b0, 4'h3, 1'b1);

      // Hold start high continuously: one op every WIDTH+2 cycles.
      @(posedge clk); #1;
      A = 4'd7; B = 4'd2; b_in = 1'b0; start = 1'b1;
      nd = 0;
      nbusy = 0;
      repeat (3 * (WIDTH + 2)) begin
         @(posedge clk); #1;
         if (done) nd++;
         if (busy) nbusy++;
      end
      start = 1'b0;
      chk("b2b_dones", nd, 3);
      chk("b2b_busy_cycles", nbusy, 3 * WIDTH);
      chk("b2b_D", D, 4'h5);
      repeat (WIDTH + 3) @(posedge clk);

      // Assert reset in the middle of SHIFT.
      do_op(4'd2, 4'd7, 1'b0, 4'hB, 1'b1);
      @(posedge clk); #1;
      A = 4'd12; B = 4'd4; b_in = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_D", D, 0);
      chk("midrst_b_out", b_out, 0);
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      nd = 0;
      repeat (WIDTH + 2) begin
         @(posedge clk); #1;
         if (done) nd++;
      end
      chk("midrst_no_done", nd, 0);
      do_op(4'd12, 4'd4, 1'b0, 4'h8, 1'b0);

      // Exhaustive sweep against the reference subtraction.
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int bi = 0; bi < 2; bi++) begin
               r = {1'b0, 4'(a)} - {1'b0, 4'(b)} - 5'(bi);
               do_op(4'(a), 4'(b), 1'(bi), r[WIDTH-1:0], r[WIDTH]);
            end

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
